axi_rd_responder: RTL and testbench
===================================

// Module: axi_rd_responder
// PURPOSE
// - AXI4 read-side slave engine: accepts AR requests, issues single-word reads to a fixed-latency SRAM port, returns R beats.
// - Sits between an AXI read channel and a memory macro; buffered R path absorbs r_ready_i backpressure without stalling the SRAM mid-access.
// - INCR bursts only; size is always the full data width.
// PARAMETERS
// - ADDR_WIDTH    32  AXI/SRAM byte address width
// - DATA_WIDTH    32  data width in bits; power of two, >= 8
// - ID_WIDTH      4   AXI ID width
// - BUFFER_DEPTH  2   R-beat buffer entries; >= 2
// PORTS
// - clk_i        in   1           clock
// - rst_ni       in   1           asynchronous reset, active low
// - ar_valid_i   in   1           AR valid
// - ar_ready_o   out  1           AR ready
// - ar_addr_i    in   ADDR_WIDTH  burst start byte address
// - ar_len_i     in   8           beats minus one
// - ar_id_i      in   ID_WIDTH    transaction ID
// - mem_req_o    out  1           SRAM read request
// - mem_gnt_i    in   1           SRAM grant
// - mem_addr_o   out  ADDR_WIDTH  SRAM byte address, word aligned
// - mem_rdata_i  in   DATA_WIDTH  read data, valid exactly 1 cycle after req&&gnt
// - r_valid_o    out  1           R valid
// - r_ready_i    in   1           R ready
// - r_data_o     out  DATA_WIDTH  R data
// - r_id_o       out  ID_WIDTH    R ID
// - r_last_o     out  1           last beat of burst
// - r_resp_o     out  2           R response
// BEHAVIOUR
// - Reset: state IDLE; ar_ready_o=1, mem_req_o=0, r_valid_o=0; r_data_o/r_id_o/r_last_o/r_resp_o=0; counters and pointers 0.
// - FSM IDLE: ar_ready_o=1. On ar_valid_i&&ar_ready_o: latch ID, len, and addr with low log2(DATA_WIDTH/8) bits cleared; beat_cnt=0; go to BURST.
// - FSM BURST: ar_ready_o=0. mem_req_o=1 while free>0:
//   free = BUFFER_DEPTH - elements - outstanding + (r_valid_o&&r_ready_i).
//   - outstanding = 1 in the cycle after a granted request, else 0.
//   - free includes a combinational path from r_ready_i; this path is intentional.
// - Request stability: while mem_req_o&&!mem_gnt_i, mem_addr_o is held and mem_req_o stays 1; credits can only rise while waiting.
// - On each grant: addr += DATA_WIDTH/8 (modulo 2^ADDR_WIDTH); beat_cnt++.
//   - Grant of beat len returns to IDLE the next cycle, so ar_ready_o=1 while earlier beats may still drain.
//   - No 4KB boundary check.
// - One cycle after a grant, push {mem_rdata_i, id, last=(beat==len), resp} into the circular buffer.
//   - Credit rule guarantees no push when full; overflow is an assertion error.
// - R outputs are driven from the buffer head: r_valid_o = (elements!=0).
//   - On r_valid_o&&r_ready_i, pop the head; pointers wrap at BUFFER_DEPTH-1.
//   - Simultaneous push and pop leaves elements unchanged.
// - Latency: AR handshake at cycle t -> mem_req_o at t+1 -> data pushed t+2 -> r_valid_o at t+3.
// - Throughput: 1 beat/cycle with gnt=1 and r_ready=1.
// - Beats leave in request order; each beat's ID and last flag are those of its own burst, including back-to-back bursts.
// - Reset asserted mid-burst: immediate return to reset values; buffered beats and in-flight reads are discarded.
// CONFIGURATION
// - AXI_RD_SLVERR_EN defined:
//   - adds input mem_err_i (1 bit), sampled with mem_rdata_i;
//   - r_resp_o=2'b10 (SLVERR) for that beat only; the burst continues.
// - AXI_RD_SLVERR_EN undefined: no mem_err_i port; r_resp_o is always 2'b00 (OKAY).
// TESTING
// - Reset, idle inputs -> ar_ready_o=1, mem_req_o=0, r_valid_o=0 held for 20 cycles.
// - AR addr=0x100 len=3 id=5, gnt=1, r_ready=1:
//   - mem_addr_o=0x100,0x104,0x108,0x10C on consecutive cycles;
//   - 4 R beats with id 5, r_last_o on beat 4 only, first r_valid_o 3 cycles after AR handshake.
// - AR addr=0x103 len=0 -> mem_addr_o=0x100; one beat with r_last_o=1.
// - len=7 burst, r_ready_i=0 for 10 cycles -> at most BUFFER_DEPTH beats buffered, mem_req_o low; after release, all 8 beats in order with no loss.
// - Random mem_gnt_i stalls -> mem_addr_o and mem_req_o stable while unganted; data order correct.
// - Back-to-back AR id=1 len=1 then id=2 len=2 -> 5 beats, ids 1,1,2,2,2, r_last_o on beats 2 and 5.
// - AXI_RD_SLVERR_EN defined, mem_err_i=1 on beat 2 of len=3 -> r_resp_o=2'b10 on beat 2 only; undefined -> all 2'b00.

Source files
------------

// File: rtl/axi_rd_responder.sv
// AXI4 read-side slave engine: accepts AR bursts, issues single-word SRAM
// reads with one-cycle read latency and returns R beats through a small
// circular buffer. A credit count keeps the buffer from overflowing, so
// r_ready_i backpressure never stalls an SRAM access that has already started.
// Optional feature macro AXI_RD_SLVERR_EN adds mem_err_i. A beat read with
// mem_err_i set returns SLVERR. Without the macro, every beat returns OKAY.
module axi_rd_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int BUFFER_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
`ifdef AXI_RD_SLVERR_EN
    input  logic                  mem_err_i,
`endif
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic                  r_last_o,
    output logic [1:0]            r_resp_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PW    = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CW    = $clog2(BUFFER_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BYTES);
    localparam logic [PW-1:0]         LAST_PTR   = PW'(BUFFER_DEPTH - 1);
    localparam logic [CW-1:0]         FULL_COUNT = CW'(BUFFER_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beatCnt_q;
    logic [ID_WIDTH-1:0]   id_q;

    logic                  outstanding_q;
    logic [ID_WIDTH-1:0]   pendId_q;
    logic                  pendLast_q;

    logic [DATA_WIDTH-1:0] dataBuf_q [BUFFER_DEPTH];
    logic [ID_WIDTH-1:0]   idBuf_q   [BUFFER_DEPTH];
    logic                  lastBuf_q [BUFFER_DEPTH];
    logic [1:0]            respBuf_q [BUFFER_DEPTH];
    logic [PW-1:0]         wrPtr_q;
    logic [PW-1:0]         rdPtr_q;
    logic [CW-1:0]         count_q;

    logic                  memFire;
    logic                  lastGrant;
    logic                  bufPush;
    logic                  bufPop;
    logic [1:0]            respIn;
    int                    freeCredits;

    assign ar_ready_o = (state_q == IDLE);
    assign mem_addr_o = addr_q;
    assign r_valid_o  = (count_q != '0);
    assign r_data_o   = dataBuf_q[rdPtr_q];
    assign r_id_o     = idBuf_q[rdPtr_q];
    assign r_last_o   = lastBuf_q[rdPtr_q];
    assign r_resp_o   = respBuf_q[rdPtr_q];

    assign bufPop    = r_valid_o && r_ready_i;
    assign bufPush   = outstanding_q;
    assign memFire   = mem_req_o && mem_gnt_i;
    assign lastGrant = (beatCnt_q == len_q);

`ifdef AXI_RD_SLVERR_EN
    assign respIn = mem_err_i ? 2'b10 : 2'b00;
`else
    assign respIn = 2'b00;
`endif

    // Credits left for new reads: a beat leaving this cycle frees its slot at once
    always_comb begin
        freeCredits = BUFFER_DEPTH - int'(count_q) - int'(outstanding_q) + int'(bufPop);
        mem_req_o   = (state_q == BURST) && (freeCredits > 0);
    end

    // Burst FSM: latch the AR request, then step the word address on every grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            beatCnt_q     <= '0;
            id_q          <= '0;
            outstanding_q <= 1'b0;
            pendId_q      <= '0;
            pendLast_q    <= 1'b0;
        end else begin
            outstanding_q <= memFire;
            pendId_q      <= id_q;
            pendLast_q    <= lastGrant;
            case (state_q)
                IDLE: begin
                    if (ar_valid_i) begin
                        addr_q    <= ar_addr_i & ~ALIGN_MASK;
                        len_q     <= ar_len_i;
                        id_q      <= ar_id_i;
                        beatCnt_q <= '0;
                        state_q   <= BURST;
                    end
                end
                BURST: begin
                    if (memFire) begin
                        addr_q    <= addr_q + ADDR_STEP;
                        beatCnt_q <= beatCnt_q + 8'd1;
                        if (lastGrant) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // R-beat circular buffer: push the read data one cycle after its grant, pop on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                dataBuf_q[i] <= '0;
                idBuf_q[i]   <= '0;
                lastBuf_q[i] <= 1'b0;
                respBuf_q[i] <= 2'b00;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (bufPush) begin
                dataBuf_q[wrPtr_q] <= mem_rdata_i;
                idBuf_q[wrPtr_q]   <= pendId_q;
                lastBuf_q[wrPtr_q] <= pendLast_q;
                respBuf_q[wrPtr_q] <= respIn;
                wrPtr_q            <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PW'(1);
            end
            if (bufPop) begin
                rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PW'(1);
            end
            if (bufPush && !bufPop) begin
                count_q <= count_q + CW'(1);
            end else if (bufPop && !bufPush) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // The credit scheme must never let a returning read land in a full buffer
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bufPush && !bufPop && (count_q == FULL_COUNT)));

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: an SRAM model answers granted reads, and a
// burst-level reference model predicts every SRAM address and every R beat.
// When AXI_RD_SLVERR_EN is defined, the bench also drives mem_err_i.
module tb_axi_rd_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          ar_valid_i = 1'b0;
    logic          ar_ready_o;
    logic [AW-1:0] ar_addr_i = '0;
    logic [7:0]    ar_len_i = '0;
    logic [IW-1:0] ar_id_i = '0;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i = '0;
`ifdef AXI_RD_SLVERR_EN
    logic          mem_err_i = 1'b0;
`endif
    logic          r_valid_o;
    logic          r_ready_i = 1'b0;
    logic [DW-1:0] r_data_o;
    logic [IW-1:0] r_id_o;
    logic          r_last_o;
    logic [1:0]    r_resp_o;

    axi_rd_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i), .ar_id_i(ar_id_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i),
`ifdef AXI_RD_SLVERR_EN
        .mem_err_i(mem_err_i),
`endif
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .r_id_o(r_id_o), .r_last_o(r_last_o), .r_resp_o(r_resp_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
    } ar_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
        logic [1:0]    resp;
    } beat_t;

    ar_t           arQ[$];
    logic [AW-1:0] expAddrQ[$];
    beat_t         expBeatQ[$];

    int            total = 0;
    int            bad = 0;
    int            cycleNo = 0;
    int            gntPct = 100;
    int            readyPct = 100;
    bit            readyLow = 1'b0;
    bit            arDone = 1'b0;
    bit            prevFire = 1'b0;
    bit            prevWait = 1'b0;
    logic [AW-1:0] prevAddr = '0;
    logic [AW-1:0] waitAddr = '0;
    int            grantsSinceAr = 0;
    bit            latEnable = 1'b0;
    bit            latCheckReq = 1'b0;
    bit            latCheckR = 1'b0;
    int            hsCycle = 0;
    bit            errOn = 1'b0;
    logic [AW-1:0] errAddr = '0;

    // Compare one observed value with its expected value and keep the tally
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycleNo);
        end
    endtask

    // SRAM contents, as a fixed scramble of the word address
    function automatic logic [DW-1:0] dataOf(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [1:0] respOf(input logic [AW-1:0] a);
`ifdef AXI_RD_SLVERR_EN
        return (errOn && a == errAddr) ? 2'b10 : 2'b00;
`else
        return (a == a) ? 2'b00 : 2'b00;
`endif
    endfunction

    // Reference model: an accepted burst expands into word addresses and R beats
    task automatic modelAccept(input ar_t r);
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        beat_t b;
        base = r.addr & ~32'h3;
        for (int i = 0; i <= int'(r.len); i++) begin
            a = base + 32'(4 * i);
            expAddrQ.push_back(a);
            b.data = dataOf(a);
            b.id   = r.id;
            b.last = (i == int'(r.len));
            b.resp = respOf(a);
            expBeatQ.push_back(b);
        end
    endtask

    task automatic addBurst(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
        ar_t r;
        r.addr = addr;
        r.len  = len;
        r.id   = id;
        arQ.push_back(r);
    endtask

    // One clock: drive inputs after the falling edge, then sample and check every handshake
    task automatic applyStimulus();
        beat_t b;
        @(negedge clk_i);
        cycleNo++;
        mem_rdata_i = prevFire ? dataOf(prevAddr) : DW'($urandom());
`ifdef AXI_RD_SLVERR_EN
        mem_err_i = prevFire ? (errOn && prevAddr == errAddr) : 1'($urandom_range(1));
`endif
        mem_gnt_i = ($urandom_range(99) < gntPct);
        r_ready_i = readyLow ? 1'b0 : ($urandom_range(99) < readyPct);
        if (arDone) begin
            ar_valid_i = 1'b0;
            arDone = 1'b0;
        end
        if (!ar_valid_i && arQ.size() > 0) begin
            ar_valid_i = 1'b1;
            ar_addr_i  = arQ[0].addr;
            ar_len_i   = arQ[0].len;
            ar_id_i    = arQ[0].id;
        end
        #1;
        if (prevWait) begin
            checkOutput("req_hold", 64'(mem_req_o), 64'd1);
            checkOutput("addr_hold", 64'(mem_addr_o), 64'(waitAddr));
        end
        if (latCheckReq && mem_req_o) begin
            checkOutput("req_latency", 64'(cycleNo - hsCycle), 64'd1);
            latCheckReq = 1'b0;
        end
        if (latCheckR && r_valid_o) begin
            checkOutput("rvalid_latency", 64'(cycleNo - hsCycle), 64'd3);
            latCheckR = 1'b0;
        end
        prevFire = mem_req_o && mem_gnt_i;
        prevWait = mem_req_o && !mem_gnt_i;
        prevAddr = mem_addr_o;
        waitAddr = mem_addr_o;
        if (prevFire) begin
            grantsSinceAr++;
            if (expAddrQ.size() == 0) checkOutput("unexpected_req", 64'd1, 64'd0);
            else checkOutput("mem_addr", 64'(mem_addr_o), 64'(expAddrQ.pop_front()));
        end
        if (r_valid_o && r_ready_i) begin
            if (expBeatQ.size() == 0) begin
                checkOutput("unexpected_beat", 64'd1, 64'd0);
            end else begin
                b = expBeatQ.pop_front();
                checkOutput("r_data", 64'(r_data_o), 64'(b.data));
                checkOutput("r_id", 64'(r_id_o), 64'(b.id));
                checkOutput("r_last", 64'(r_last_o), 64'(b.last));
                checkOutput("r_resp", 64'(r_resp_o), 64'(b.resp));
            end
        end
        if (ar_valid_i && ar_ready_o) begin
            modelAccept(arQ.pop_front());
            arDone = 1'b1;
            hsCycle = cycleNo;
            grantsSinceAr = 0;
            if (latEnable) begin
                latCheckReq = 1'b1;
                latCheckR = 1'b1;
                latEnable = 1'b0;
            end
        end
    endtask

    // Run until every queued burst has been issued and all predicted beats have returned
    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while ((arQ.size() > 0 || expBeatQ.size() > 0) && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_beats_left", 64'(expBeatQ.size() + arQ.size()), 64'd0);
        checkOutput("drain_addrs_left", 64'(expAddrQ.size()), 64'd0);
    endtask

    initial begin
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rst_ar_ready", 64'(ar_ready_o), 64'd1);
        checkOutput("rst_mem_req", 64'(mem_req_o), 64'd0);
        checkOutput("rst_r_valid", 64'(r_valid_o), 64'd0);
        checkOutput("rst_r_fields", {r_data_o, 25'd0, r_id_o, r_last_o, r_resp_o}, 64'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] idle after reset");
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            checkOutput("idle_ar_ready", 64'(ar_ready_o), 64'd1);
            checkOutput("idle_mem_req", 64'(mem_req_o), 64'd0);
            checkOutput("idle_r_valid", 64'(r_valid_o), 64'd0);
        end

        $display("[TB] basic burst with latency check");
        latEnable = 1'b1;
        addBurst(32'h100, 8'd3, 4'd5);
        waitDrain(100);

        $display("[TB] unaligned single beat");
        addBurst(32'h103, 8'd0, 4'd9);
        waitDrain(100);

        $display("[TB] backpressure holds the buffer at its depth");
        readyLow = 1'b1;
        addBurst(32'h2000, 8'd7, 4'd3);
        repeat (12) applyStimulus();
        checkOutput("bp_mem_req_low", 64'(mem_req_o), 64'd0);
        checkOutput("bp_grants", 64'(grantsSinceAr), 64'(DEPTH));
        checkOutput("bp_r_valid", 64'(r_valid_o), 64'd1);
        readyLow = 1'b0;
        waitDrain(200);

        $display("[TB] back-to-back bursts");
        addBurst(32'h40, 8'd1, 4'd1);
        addBurst(32'h80, 8'd2, 4'd2);
        waitDrain(100);

        $display("[TB] error on second beat");
        errOn = 1'b1;
        errAddr = 32'h304;
        addBurst(32'h300, 8'd3, 4'd7);
        waitDrain(100);
        errOn = 1'b0;

        $display("[TB] random bursts with grant stalls and backpressure");
        gntPct = 60;
        readyPct = 70;
        for (int i = 0; i < 30; i++) begin
            addBurst(AW'($urandom()), 8'($urandom_range(15)), IW'($urandom()));
        end
        waitDrain(4000);

        $display("[TB] reset in the middle of a burst");
        gntPct = 100;
        readyPct = 0;
        addBurst(32'h500, 8'd7, 4'd4);
        repeat (4) applyStimulus();
        @(negedge clk_i);
        rst_ni = 1'b0;
        ar_valid_i = 1'b0;
        arQ.delete();
        expAddrQ.delete();
        expBeatQ.delete();
        prevFire = 1'b0;
        prevWait = 1'b0;
        arDone = 1'b0;
        #1;
        checkOutput("midrst_ar_ready", 64'(ar_ready_o), 64'd1);
        checkOutput("midrst_mem_req", 64'(mem_req_o), 64'd0);
        checkOutput("midrst_r_valid", 64'(r_valid_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        readyPct = 100;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("post_rst_r_valid", 64'(r_valid_o), 64'd0);
            checkOutput("post_rst_mem_req", 64'(mem_req_o), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
